// File: rtl/sum_nregs_pipe.sv
// sum_nregs_pipe: pipelined N-input adder tree plus a multi-beat accumulator closed by in_last.
// Latency: a last beat accepted in cycle T gives out_valid in cycle T+LEVELS+1; throughput 1 beat/cycle.
// Backpressure: the whole pipeline freezes while out_valid & ~out_ready; in_ready = ~stall.
// Optional build macro SUM_NREGS_PIPE_SAT_EN: saturating accumulation instead of modulo wrap.
module sum_nregs_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_INPUTS = 3,
  parameter int SIGNED     = 0,
  parameter int ACC_BITS   = 4,
  localparam int LEVELS    = $clog2(NUM_INPUTS),
  localparam int OUT_WIDTH = DATA_WIDTH + LEVELS + ACC_BITS
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic                             in_valid,
  input  logic                             in_last,
  output logic                             in_ready,
  output logic [OUT_WIDTH-1:0]             out_data,
  output logic                             out_valid,
  input  logic                             out_ready
);

  localparam int EXT = OUT_WIDTH - DATA_WIDTH;

  logic                 stall;
  logic [OUT_WIDTH-1:0] tree_out;
  logic                 tree_vld;
  logic                 tree_lst;
  logic [OUT_WIDTH-1:0] acc;
  logic                 first;
  logic [OUT_WIDTH-1:0] base;
  logic [OUT_WIDTH-1:0] sum;

  // An unconsumed result blocks everything upstream, so nothing can be lost.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // Level k holds ceil(NUM_INPUTS / 2^k) partial sums; level 0 is the accepted
  // input itself, every later level is a register stage with its own valid/last.
  for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
    localparam int CNT = (NUM_INPUTS + (1 << k) - 1) >> k;

    logic [CNT*OUT_WIDTH-1:0] node;
    logic                     vld;
    logic                     lst;

    if (k == 0) begin : g_in
      assign vld = in_valid & in_ready;
      assign lst = in_last & vld;
      for (genvar j = 0; j < CNT; j++) begin : g_ext
        logic [DATA_WIDTH-1:0] op;
        assign op = in_data[j*DATA_WIDTH +: DATA_WIDTH];
        if (SIGNED != 0) begin : g_sx
          assign node[j*OUT_WIDTH +: OUT_WIDTH] = {{EXT{op[DATA_WIDTH-1]}}, op};
        end else begin : g_zx
          assign node[j*OUT_WIDTH +: OUT_WIDTH] = {{EXT{1'b0}}, op};
        end
      end
    end else begin : g_stage
      localparam int PCNT = (NUM_INPUTS + (1 << (k - 1)) - 1) >> (k - 1);

      logic [CNT*OUT_WIDTH-1:0] pair_sum;

      for (genvar j = 0; j < CNT; j++) begin : g_pair
        if (2 * j + 1 < PCNT) begin : g_add
          assign pair_sum[j*OUT_WIDTH +: OUT_WIDTH] =
            g_lvl[k-1].node[(2*j)*OUT_WIDTH +: OUT_WIDTH] +
            g_lvl[k-1].node[(2*j+1)*OUT_WIDTH +: OUT_WIDTH];
        end else begin : g_pass
          // Odd element out at this level rides through unchanged.
          assign pair_sum[j*OUT_WIDTH +: OUT_WIDTH] =
            g_lvl[k-1].node[(2*j)*OUT_WIDTH +: OUT_WIDTH];
        end
      end

      // Tree stage register: advances data, valid and last together unless stalled.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          node <= '0;
          vld  <= 1'b0;
          lst  <= 1'b0;
        end else if (!stall) begin
          node <= pair_sum;
          vld  <= g_lvl[k-1].vld;
          lst  <= g_lvl[k-1].lst;
        end
      end
    end
  end

  assign tree_out = g_lvl[LEVELS].node;
  assign tree_vld = g_lvl[LEVELS].vld;
  assign tree_lst = g_lvl[LEVELS].lst;

  // First beat of a group starts from zero rather than the stale accumulator.
  assign base = first ? '0 : acc;

`ifdef SUM_NREGS_PIPE_SAT_EN
  logic [OUT_WIDTH:0] wide;

  // Saturating add: one extra bit exposes overflow, which clamps to the range limit.
  always_comb begin
    wide = '0;
    sum  = '0;
    if (SIGNED != 0) begin
      wide = {base[OUT_WIDTH-1], base} + {tree_out[OUT_WIDTH-1], tree_out};
      if (wide[OUT_WIDTH] != wide[OUT_WIDTH-1]) begin
        sum = wide[OUT_WIDTH] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                              : {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end else begin
        sum = wide[OUT_WIDTH-1:0];
      end
    end else begin
      wide = {1'b0, base} + {1'b0, tree_out};
      sum  = wide[OUT_WIDTH] ? '1 : wide[OUT_WIDTH-1:0];
    end
  end
`else
  assign sum = base + tree_out;
`endif

  // Accumulator and output register: a last beat publishes the group sum and
  // re-arms the accumulator; a consumed output with no replacement drops valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      first     <= 1'b1;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      if (tree_vld && tree_lst) begin
        out_data  <= sum;
        out_valid <= 1'b1;
        acc       <= '0;
        first     <= 1'b1;
      end else begin
        out_valid <= 1'b0;
        if (tree_vld) begin
          acc   <= sum;
          first <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sum_nregs_pipe.sv
// Bench for sum_nregs_pipe: three configurations (unsigned 16x3, signed 8x5, tiny 4x2 without guard bits).
// Drivers update a per-group reference model on every accepted beat and queue the expected group sums;
// monitors pop and compare on each output handshake, and also check hold/in_ready behaviour under stall.
module tb_sum_nregs_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT A: DATA_WIDTH=16, NUM_INPUTS=3, unsigned, ACC_BITS=4 -> OUT_WIDTH=22
  logic [47:0] a_in_data = '0;
  logic        a_in_valid = 1'b0, a_in_last = 1'b0, a_in_ready;
  logic [21:0] a_out_data;
  logic        a_out_valid, a_out_ready = 1'b1;
  // DUT B: DATA_WIDTH=8, NUM_INPUTS=5, signed, ACC_BITS=4 -> OUT_WIDTH=15
  logic [39:0] b_in_data = '0;
  logic        b_in_valid = 1'b0, b_in_last = 1'b0, b_in_ready;
  logic [14:0] b_out_data;
  logic        b_out_valid, b_out_ready = 1'b1;
  // DUT C: DATA_WIDTH=4, NUM_INPUTS=2, unsigned, ACC_BITS=0 -> OUT_WIDTH=5
  logic [7:0]  c_in_data = '0;
  logic        c_in_valid = 1'b0, c_in_last = 1'b0, c_in_ready;
  logic [4:0]  c_out_data;
  logic        c_out_valid, c_out_ready = 1'b1;

  sum_nregs_pipe #(.DATA_WIDTH(16), .NUM_INPUTS(3), .SIGNED(0), .ACC_BITS(4)) u_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid), .in_last(a_in_last),
    .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready));
  sum_nregs_pipe #(.DATA_WIDTH(8), .NUM_INPUTS(5), .SIGNED(1), .ACC_BITS(4)) u_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_last(b_in_last),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready));
  sum_nregs_pipe #(.DATA_WIDTH(4), .NUM_INPUTS(2), .SIGNED(0), .ACC_BITS(0)) u_c (
    .clk(clk), .rst(rst), .in_data(c_in_data), .in_valid(c_in_valid), .in_last(c_in_last),
    .in_ready(c_in_ready), .out_data(c_out_data), .out_valid(c_out_valid), .out_ready(c_out_ready));

  int n_chk  = 0;
  int n_pass = 0;
  longint qa[$], qb[$], qc[$];
  longint acc_a = 0, acc_b = 0, acc_c = 0;
  bit rnd_ready = 1'b0;

  function automatic void check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endfunction

  // One accumulator step as the behaviour defines it: wrap modulo 2^ow, or clamp to range.
  function automatic longint acc_step(input longint acc, input longint beat, input int ow, input bit sgn);
    longint m = longint'(1) << ow;
    longint s = acc + beat;
`ifdef SUM_NREGS_PIPE_SAT_EN
    longint mx = sgn ? (m / 2) - 1 : m - 1;
    longint mn = sgn ? -(m / 2) : 0;
    if (s > mx) s = mx;
    if (s < mn) s = mn;
`else
    s = ((s % m) + m) % m;
    if (sgn && s >= m / 2) s = s - m;
`endif
    return s;
  endfunction

  function automatic longint pattern(input longint v, input int ow);
    return v & ((longint'(1) << ow) - 1);
  endfunction

  // Each send task is entered at a falling edge, holds the beat until it is
  // accepted (bounded), then updates that DUT's model.
  task automatic send_a(input logic [47:0] d, input bit last);
    bit ok = 1'b0;
    int w = 0;
    longint beat = 0;
    a_in_data = d; a_in_last = last; a_in_valid = 1'b1;
    while (!ok && w < 200) begin
      #1 ok = a_in_ready;
      @(posedge clk);
      @(negedge clk);
      w++;
    end
    a_in_valid = 1'b0;
    check("a_accept", ok, 1);
    if (ok) begin
      for (int i = 0; i < 3; i++) beat += longint'(d[i*16 +: 16]);
      acc_a = acc_step(acc_a, beat, 22, 1'b0);
      if (last) begin qa.push_back(pattern(acc_a, 22)); acc_a = 0; end
    end
  endtask

  task automatic send_b(input logic [39:0] d, input bit last);
    bit ok = 1'b0;
    int w = 0;
    longint beat = 0;
    b_in_data = d; b_in_last = last; b_in_valid = 1'b1;
    while (!ok && w < 200) begin
      #1 ok = b_in_ready;
      @(posedge clk);
      @(negedge clk);
      w++;
    end
    b_in_valid = 1'b0;
    check("b_accept", ok, 1);
    if (ok) begin
      for (int i = 0; i < 5; i++) beat += longint'($signed(d[i*8 +: 8]));
      acc_b = acc_step(acc_b, beat, 15, 1'b1);
      if (last) begin qb.push_back(pattern(acc_b, 15)); acc_b = 0; end
    end
  endtask

  task automatic send_c(input logic [7:0] d, input bit last);
    bit ok = 1'b0;
    int w = 0;
    longint beat = 0;
    c_in_data = d; c_in_last = last; c_in_valid = 1'b1;
    while (!ok && w < 200) begin
      #1 ok = c_in_ready;
      @(posedge clk);
      @(negedge clk);
      w++;
    end
    c_in_valid = 1'b0;
    check("c_accept", ok, 1);
    if (ok) begin
      for (int i = 0; i < 2; i++) beat += longint'(d[i*4 +: 4]);
      acc_c = acc_step(acc_c, beat, 5, 1'b0);
      if (last) begin qc.push_back(pattern(acc_c, 5)); acc_c = 0; end
    end
  endtask

  task automatic drain();
    int n = 0;
    a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1;
    while ((qa.size() + qb.size() + qc.size()) != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    check("drain_pending", qa.size() + qb.size() + qc.size(), 0);
  endtask

  task automatic rand_a(input int n);
    logic [63:0] r;
    for (int i = 0; i < n; i++) begin
      r = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      send_a(r[47:0], ($urandom_range(0, 2) == 0) || (i == n - 1));
    end
  endtask

  task automatic rand_b(input int n);
    logic [63:0] r;
    for (int i = 0; i < n; i++) begin
      r = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      send_b(r[39:0], ($urandom_range(0, 3) == 0) || (i == n - 1));
    end
  endtask

  task automatic rand_c(input int n);
    logic [31:0] r;
    for (int i = 0; i < n; i++) begin
      r = $urandom();
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      send_c(r[7:0], ($urandom_range(0, 2) == 0) || (i == n - 1));
    end
  endtask

  // Random downstream readiness during the soak phase.
  always @(negedge clk) begin
    if (rnd_ready) begin
      a_out_ready = ($urandom_range(0, 9) < 7);
      b_out_ready = ($urandom_range(0, 9) < 6);
      c_out_ready = ($urandom_range(0, 9) < 7);
    end
  end

  // Monitors: compare on handshake, require hold and in_ready low while stalled.
  logic        a_prev_stall = 1'b0, b_prev_stall = 1'b0, c_prev_stall = 1'b0;
  logic [21:0] a_prev_data = '0;
  logic [14:0] b_prev_data = '0;
  logic [4:0]  c_prev_data = '0;

  always @(negedge clk) begin
    #2;
    if (rst) a_prev_stall = 1'b0;
    else begin
      if (a_prev_stall) begin
        check("a_hold_valid", a_out_valid, 1);
        check("a_hold_data", a_out_data, a_prev_data);
      end
      if (a_out_valid && !a_out_ready) check("a_in_ready_stall", a_in_ready, 0);
      if (a_out_valid && a_out_ready) begin
        check("a_out_expected", qa.size() != 0, 1);
        if (qa.size() != 0) check("a_out_data", a_out_data, qa.pop_front());
      end
      a_prev_stall = a_out_valid && !a_out_ready;
      a_prev_data  = a_out_data;
    end
  end

  always @(negedge clk) begin
    #2;
    if (rst) b_prev_stall = 1'b0;
    else begin
      if (b_prev_stall) begin
        check("b_hold_valid", b_out_valid, 1);
        check("b_hold_data", b_out_data, b_prev_data);
      end
      if (b_out_valid && !b_out_ready) check("b_in_ready_stall", b_in_ready, 0);
      if (b_out_valid && b_out_ready) begin
        check("b_out_expected", qb.size() != 0, 1);
        if (qb.size() != 0) check("b_out_data", b_out_data, qb.pop_front());
      end
      b_prev_stall = b_out_valid && !b_out_ready;
      b_prev_data  = b_out_data;
    end
  end

  always @(negedge clk) begin
    #2;
    if (rst) c_prev_stall = 1'b0;
    else begin
      if (c_prev_stall) begin
        check("c_hold_valid", c_out_valid, 1);
        check("c_hold_data", c_out_data, c_prev_data);
      end
      if (c_out_valid && !c_out_ready) check("c_in_ready_stall", c_in_ready, 0);
      if (c_out_valid && c_out_ready) begin
        check("c_out_expected", qc.size() != 0, 1);
        if (qc.size() != 0) check("c_out_data", c_out_data, qc.pop_front());
      end
      c_prev_stall = c_out_valid && !c_out_ready;
      c_prev_data  = c_out_data;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    // Reset state
    check("rst_a_out_valid", a_out_valid, 0);
    check("rst_a_out_data", a_out_data, 0);
    check("rst_a_in_ready", a_in_ready, 1);
    check("rst_b_out_valid", b_out_valid, 0);
    check("rst_b_out_data", b_out_data, 0);
    check("rst_c_in_ready", c_in_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // Single-beat max: result 0x2FFFD lands three cycles after acceptance, for one cycle
    send_a(48'hFFFF_FFFF_FFFF, 1'b1);
    check("lat_t1_valid", a_out_valid, 0);
    @(negedge clk);
    check("lat_t2_valid", a_out_valid, 0);
    @(negedge clk);
    check("lat_t3_valid", a_out_valid, 1);
    check("lat_t3_data", a_out_data, 22'h2FFFD);
    @(negedge clk);
    check("lat_t4_valid", a_out_valid, 0);

    // Accumulation: 4 x {1,2,3} -> 24, then {5,5,5} -> 15
    for (int i = 0; i < 4; i++) send_a({16'd3, 16'd2, 16'd1}, i == 3);
    send_a({16'd5, 16'd5, 16'd5}, 1'b1);
    drain();

    // Backpressure: sums 1..8 back to back, out_ready low for 5 cycles mid-stream
    fork
      for (int k = 1; k <= 8; k++) send_a({16'd0, 16'd0, 16'(k)}, 1'b1);
      begin
        repeat (5) @(negedge clk);
        a_out_ready = 1'b0;
        repeat (5) @(negedge clk);
        a_out_ready = 1'b1;
      end
    join
    drain();

    // Signed: {-1,-1,5,-128,127} -> 2, then {-128 x5} -> -640
    send_b({8'd127, 8'h80, 8'd5, 8'hFF, 8'hFF}, 1'b1);
    send_b({5{8'h80}}, 1'b1);
    // Overflow: 3 x {15,15} -> 26 wrapping, 31 saturating
    send_c(8'hFF, 1'b0);
    send_c(8'hFF, 1'b0);
    send_c(8'hFF, 1'b1);
    drain();

    // Reset mid-group: partial sum of two beats must be discarded
    send_a({16'd1, 16'd1, 16'd1}, 1'b0);
    send_a({16'd1, 16'd1, 16'd1}, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", a_out_valid, 0);
    check("midrst_out_data", a_out_data, 0);
    acc_a = 0; acc_b = 0; acc_c = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_a({16'd1, 16'd1, 16'd1}, 1'b1);
    drain();

    // Randomised soak on all three configurations with random backpressure
    rnd_ready = 1'b1;
    fork
      rand_a(200);
      rand_b(200);
      rand_c(200);
    join
    rnd_ready = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sum_nregs_pipe.md
Name: sum_nregs_pipe

Overview:
- Pipelined, parametrised N-input adder tree with an optional multi-beat accumulator, used in the convolution datapath to reduce kernel-row partial products into one sum per output pixel.
- Generalises the 3-input combinational row adder:
  - any input count and signedness;
  - registered tree levels;
  - valid/ready flow control with full backpressure;
  - accumulation across beats delimited by in_last.

Parameters:
- DATA_WIDTH, 16: width of each input operand.
- NUM_INPUTS, 3: operands per beat; legal range 2..16.
- SIGNED, 0: 0 = operands zero-extended; 1 = two's-complement, sign-extended.
- ACC_BITS, 4: extra guard bits for multi-beat accumulation; 0 is legal.
- Derived: LEVELS = clog2(NUM_INPUTS); OUT_WIDTH = DATA_WIDTH + LEVELS + ACC_BITS.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  NUM_INPUTS*DATA_WIDTH  packed operands; operand i at [i*DATA_WIDTH +: DATA_WIDTH].
- in_valid  input  1  in_data/in_last valid.
- in_last  input  1  final beat of an accumulation group.
- in_ready  output  1  block accepts a beat this cycle.
- out_data  output  OUT_WIDTH  group sum.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.

Behaviour:
- **Clock and reset:** single clock domain. Reset is asynchronous and active-high; the block is held in reset while rst=1.
- **Reset state:**
  - all stage valid bits 0;
  - tree registers 0;
  - accumulator 0;
  - accumulator "first" flag 1;
  - out_data 0;
  - out_valid 0;
  - in_ready 1 (combinational, see below).
- **Stall:**
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - A beat is accepted when in_valid & in_ready.
  - While stall=1, every pipeline register, valid bit, accumulator and out_data hold their values.
- **Adder tree:**
  - Operands are extended to OUT_WIDTH per SIGNED.
  - Tree level k adds pairs from level k-1; an odd element passes through unchanged.
  - Each of the LEVELS levels is registered. Level 0 is the accepted input, combinational into level 1.
  - Each stage carries its own valid bit and last bit, advancing when ~stall.
  - Bubbles (valid=0) propagate and never update the accumulator.
- **Accumulator stage:** one further register. When the tree output is valid and ~stall:
  - sum = (first ? 0 : acc) + tree_out, computed modulo 2^OUT_WIDTH by default.
  - If last=1: out_data <= sum, out_valid <= 1, acc <= 0, first <= 1.
  - If last=0: acc <= sum, first <= 0, out_valid clears if the current output handshakes.
- **Output handshake:**
  - Output completes when out_valid & out_ready.
  - If no new result arrives that cycle, out_valid <= 0 and out_data holds its value.
  - Handshake plus new last-result in the same cycle: out_valid stays 1 and out_data takes the new sum. No loss, no duplicate.
- **Latency:** a last beat accepted in cycle T yields out_valid=1 in cycle T+LEVELS+1, absent stalls. Throughput is 1 beat/cycle.
- **Single-beat groups:** in_last=1 on every beat gives a plain pipelined N-way sum.
- **Mid-operation reset:** reset discards all in-flight beats and any partial accumulation. The first accepted beat after reset starts a new group.
- **Invalid-input rule:** in_last, in_data and in_valid are don't-care when not accepted; the block never samples them while in_ready=0.

Optional Feature:
- Macro: SUM_NREGS_PIPE_SAT_EN.
- **Defined:** the accumulator add saturates instead of wrapping.
  - Unsigned: clamp to 2^OUT_WIDTH-1.
  - Signed: clamp to the OUT_WIDTH two's-complement max or min.
  - Saturation applies to both acc updates and out_data loads. A saturated acc continues to saturate for the rest of the group.
- **Not defined:** modulo-2^OUT_WIDTH wrap; no saturation logic is synthesised.
- Pipeline latency is identical in both builds.

Test Plan:
1. **Single-beat max:** DATA_WIDTH=16, NUM_INPUTS=3, SIGNED=0, ACC_BITS=4. One beat {0xFFFF,0xFFFF,0xFFFF}, in_last=1, at cycle T -> out_valid at T+3 with out_data=0x2FFFD; out_valid drops after 1 cycle with out_ready=1.
2. **Accumulation:** same config. 4 consecutive beats {1,2,3}, in_last on the 4th -> exactly one output, 24; no output on beats 1-3. Next single beat {5,5,5} last -> 15 (accumulator cleared).
3. **Backpressure:** 8 back-to-back single-beat groups with sums 1..8, out_ready held low 5 cycles mid-stream -> in_ready low during stall, out_data stable while out_valid & ~out_ready, outputs 1..8 in order, none lost or duplicated.
4. **Signed:** SIGNED=1, DATA_WIDTH=8, NUM_INPUTS=5, inputs {-1,-1,5,-128,127}, last -> 2 (OUT_WIDTH=15, 0x0002). Second beat {-128 x5} -> -640.
5. **Reset mid-group:** 2 beats {1,1,1} accepted without last, rst pulsed for 1 cycle, then {1,1,1} with last -> 3, not 9; out_valid=0 and out_data=0 immediately on rst assertion.
6. **Overflow:** DATA_WIDTH=4, NUM_INPUTS=2, ACC_BITS=0, SIGNED=0 (OUT_WIDTH=5). Three beats {15,15}, last on the 3rd -> 26 without SUM_NREGS_PIPE_SAT_EN; 31 with it.
